// File: rtl/demo_seq_pkg.sv
// Shared types, layer masks and the saturating fade helper for demo_sequencer.
package demo_seq_pkg;

    typedef enum logic [1:0] {
        FADE_IN  = 2'd0,
        HOLD     = 2'd1,
        FADE_OUT = 2'd2
    } seq_state_t;

    localparam int LAYER_PLANE  = 0;
    localparam int LAYER_STAR   = 1;
    localparam int LAYER_SCROLL = 2;
    localparam int LAYER_W      = 3;

    localparam logic [LAYER_W-1:0] EN_PLANE  = LAYER_W'(1 << LAYER_PLANE);
    localparam logic [LAYER_W-1:0] EN_STAR   = LAYER_W'(1 << LAYER_STAR);
    localparam logic [LAYER_W-1:0] EN_SCROLL = LAYER_W'(1 << LAYER_SCROLL);

    // Entry [n] is the layer mask for scene n: 010, 110, 011, 111.
    localparam logic [3:0][LAYER_W-1:0] SCENE_LAYERS = {
        EN_SCROLL | EN_STAR | EN_PLANE,
        EN_STAR | EN_PLANE,
        EN_SCROLL | EN_STAR,
        EN_STAR
    };

    localparam logic [5:0] FADE_MAX = 6'd63;

    function automatic logic [5:0] fade_step(input logic [5:0] cur,
                                             input logic [5:0] step,
                                             input logic       up);
        logic [6:0] sum;
        if (up) begin
            sum = {1'b0, cur} + {1'b0, step};
            return (sum > {1'b0, FADE_MAX}) ? FADE_MAX : sum[5:0];
        end
        sum = {1'b0, cur} - {1'b0, step};
        return sum[6] ? 6'd0 : sum[5:0];
    endfunction

endpackage

// File: rtl/demo_sequencer.sv
// Frame-rate scene timeline: fade in, hold, fade out, advance; all changes on accepted frame ticks.
// Optional DEMO_SEQ_FADE_EN enables the brightness ramp; without it fade stays at full scale.
module demo_sequencer
    import demo_seq_pkg::*;
#(
    parameter int NUM_SCENES  = 4,
    parameter int HOLD_FRAMES = 300,
    parameter int FADE_STEP   = 4,
    parameter int FRAME_W     = 11
) (
    input  logic               clk48,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               pause,
    input  logic               skip,
    output logic [1:0]         scene,
    output logic [5:0]         fade,
    output logic [LAYER_W-1:0] layer_en,
    output logic               scene_start,
    output logic [FRAME_W-1:0] scene_frame
);

    localparam int         HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [5:0] STEP   = 6'(FADE_STEP);

    seq_state_t          r_state,  w_state_n;
    logic [1:0]          r_scene,  w_scene_n;
    logic [LAYER_W-1:0]  r_layer,  w_layer_n;
    logic                r_start,  w_start_n;
    logic [FRAME_W-1:0]  r_frame,  w_frame_n;
    logic [HOLD_W-1:0]   r_hold_cnt, w_hold_n;
    logic                r_skip_pend, w_skip_n;
    logic [5:0]          w_fade_n;
    logic                w_accept;
    logic                w_advance;

`ifdef DEMO_SEQ_FADE_EN
    logic [5:0]          r_fade;
`else
    // Without ramping, brightness sits at the saturated top of a fade-in step.
    localparam logic [5:0] r_fade = fade_step(FADE_MAX, STEP, 1'b1);
`endif

    assign w_accept = frame_tick & ~pause;

    always_comb begin
        w_state_n = r_state;
        w_scene_n = r_scene;
        w_layer_n = r_layer;
        w_start_n = 1'b0;
        w_frame_n = r_frame;
        w_hold_n  = r_hold_cnt;
        w_skip_n  = r_skip_pend | skip;
        w_fade_n  = r_fade;
        w_advance = 1'b0;
        if (w_accept) begin
            // A skip arriving with this tick is kept for the next one.
            w_skip_n = skip;
            case (r_state)
                FADE_IN: begin
                    if (r_skip_pend) begin
                        w_state_n = FADE_OUT;
                    end else begin
`ifdef DEMO_SEQ_FADE_EN
                        w_fade_n = fade_step(r_fade, STEP, 1'b1);
                        if (w_fade_n == FADE_MAX) begin
                            w_state_n = HOLD;
                            w_hold_n  = '0;
                        end
`else
                        w_state_n = HOLD;
                        w_hold_n  = '0;
`endif
                    end
                end
                HOLD: begin
                    w_hold_n = r_hold_cnt + 1'b1;
                    if (r_hold_cnt == HOLD_W'(HOLD_FRAMES - 1) || r_skip_pend)
                        w_state_n = FADE_OUT;
                end
                FADE_OUT: begin
`ifdef DEMO_SEQ_FADE_EN
                    w_fade_n = fade_step(r_fade, STEP, 1'b0);
                    w_advance = (w_fade_n == 6'd0);
`else
                    w_advance = 1'b1;
`endif
                end
                default: w_state_n = FADE_IN;
            endcase
            // Scene and layers only change here, where brightness is zero.
            if (w_advance) begin
                w_scene_n = (r_scene == 2'(NUM_SCENES - 1)) ? 2'd0 : r_scene + 2'd1;
                w_layer_n = SCENE_LAYERS[w_scene_n];
                w_frame_n = '0;
                w_start_n = 1'b1;
                w_state_n = FADE_IN;
            end else if (r_frame != '1) begin
                w_frame_n = r_frame + 1'b1;
            end
        end
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            r_state     <= FADE_IN;
            r_scene     <= 2'd0;
            r_layer     <= SCENE_LAYERS[0];
            r_start     <= 1'b0;
            r_frame     <= '0;
            r_hold_cnt  <= '0;
            r_skip_pend <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_scene     <= w_scene_n;
            r_layer     <= w_layer_n;
            r_start     <= w_start_n;
            r_frame     <= w_frame_n;
            r_hold_cnt  <= w_hold_n;
            r_skip_pend <= w_skip_n;
        end
    end

`ifdef DEMO_SEQ_FADE_EN
    always_ff @(posedge clk48) begin
        if (rst) r_fade <= 6'd0;
        else     r_fade <= w_fade_n;
    end
`endif

    assign scene       = r_scene;
    assign fade        = r_fade;
    assign layer_en    = r_layer;
    assign scene_start = r_start;
    assign scene_frame = r_frame;

endmodule
